// File: rtl/axis_block_tx.sv
// Serializes 128-bit FIFO blocks into 32-bit AXI-Stream beats, MSW first, TLAST closing the packet.
// Define AXIS_TX_BSWAP_EN to byte-reverse every beat; word order and timing are unaffected.
module axis_block_tx #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned AXIS_WIDTH = 32,
    parameter int unsigned WORDS      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_start,
    input  logic [CNT_WIDTH-1:0]  tx_blocks,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_read_tvalid,
    output logic                  fifo_read_tready,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  blocks_left_q;
    logic [DATA_WIDTH-1:0] block_q;
    logic [IdxW-1:0]       word_idx_q;
    logic                  done_q;
    logic [AXIS_WIDTH-1:0] word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            blocks_left_q <= '0;
            block_q       <= '0;
            word_idx_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (tx_start && (tx_blocks != '0)) begin
                        blocks_left_q <= tx_blocks;
                        state_q       <= StFetch;
                    end
                end
                StFetch: begin
                    if (fifo_read_tvalid) begin
                        block_q    <= fifo_rdata;
                        word_idx_q <= '0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    if (m_axis_tready) begin
                        if (word_idx_q != LastIdx) begin
                            word_idx_q <= word_idx_q + 1'b1;
                            // The beat on the wire is always the top word of block_q.
                            block_q    <= block_q << AXIS_WIDTH;
                        end else begin
                            blocks_left_q <= blocks_left_q - 1'b1;
                            if (blocks_left_q == CNT_WIDTH'(1)) begin
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StFetch;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign word = block_q[DATA_WIDTH-1 -: AXIS_WIDTH];

`ifdef AXIS_TX_BSWAP_EN
    function automatic logic [AXIS_WIDTH-1:0] bswap(input logic [AXIS_WIDTH-1:0] w);
        logic [AXIS_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AXIS_WIDTH / 8; i++) begin
            r[8*i +: 8] = w[AXIS_WIDTH-8-8*i +: 8];
        end
        return r;
    endfunction

    assign m_axis_tdata = bswap(word);
`else
    assign m_axis_tdata = word;
`endif

    assign m_axis_tvalid    = (state_q == StSend);
    assign m_axis_tlast     = (state_q == StSend) && (word_idx_q == LastIdx) &&
                              (blocks_left_q == CNT_WIDTH'(1));
    assign fifo_read_tready = (state_q == StFetch);
    assign busy             = (state_q != StIdle);
    assign done             = done_q;

endmodule

// File: tb/tb_axis_block_tx.sv
// Directed and randomized bench for axis_block_tx against a queue-based packet model.
module tb_axis_block_tx;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tx_start = 1'b0;
    logic [15:0]  tx_blocks = '0;
    logic         busy, done;
    logic [127:0] fifo_rdata = '0;
    logic         fifo_read_tvalid = 1'b0;
    logic         fifo_read_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;

    always #5 clk = ~clk;

    axis_block_tx dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tx_start         (tx_start),
        .tx_blocks        (tx_blocks),
        .busy             (busy),
        .done             (done),
        .fifo_rdata       (fifo_rdata),
        .fifo_read_tvalid (fifo_read_tvalid),
        .fifo_read_tready (fifo_read_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast)
    );

    logic [127:0] fifo_q[$];
    logic [32:0]  exp_q[$];
    logic [32:0]  obs_q[$];
    bit           pat_q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_reads = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
    int bad_empty = 0;
    bit rand_ready = 0, rand_fifo = 0, watch_empty = 0, prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference beat: word w of the block counting from the most significant end.
    function automatic logic [31:0] model_beat(input logic [127:0] blk, input int w);
        logic [31:0] v;
        v = 32'(blk >> (96 - 32 * w));
`ifdef AXIS_TX_BSWAP_EN
        v = {v[7:0], v[15:8], v[23:16], v[31:24]};
`endif
        return v;
    endfunction

    task automatic add_exp(input logic [127:0] blk, input bit last_blk);
        for (int w = 0; w < 4; w++) exp_q.push_back({last_blk && (w == 3), model_beat(blk, w)});
    endtask

    task automatic fill(input int n);
        logic [127:0] blk;
        for (int i = 0; i < n; i++) begin
            blk = rnd128();
            fifo_q.push_back(blk);
            add_exp(blk, i == n - 1);
        end
    endtask

    // Entered at a negedge: sample outputs, drive inputs, log handshakes, advance one cycle.
    task automatic cycle();
        bit mhs, fhs;
        if (prev_stall) begin
            chk("stall_valid", m_axis_tvalid, 1);
            chk("stall_data", m_axis_tdata, prev_data);
            chk("stall_last", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && pat_q.size() > 0) m_axis_tready = pat_q.pop_front();
        else if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        else m_axis_tready = 1'b1;
        fifo_read_tvalid = (fifo_q.size() > 0) && (!rand_fifo || $urandom_range(0, 3) != 0);
        fifo_rdata = fifo_read_tvalid ? fifo_q[0] : rnd128();
        fhs = fifo_read_tvalid && fifo_read_tready;
        mhs = m_axis_tvalid && m_axis_tready;
        if (fhs) begin
            void'(fifo_q.pop_front());
            n_reads++;
        end
        if (mhs) begin
            obs_q.push_back({m_axis_tlast, m_axis_tdata});
            if (m_axis_tlast) last_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (watch_empty && (fifo_read_tready !== 1'b1 || m_axis_tvalid !== 1'b0)) bad_empty++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        cyc++;
        @(negedge clk);
    endtask

    task automatic start(input int n);
        tx_start = 1'b1;
        tx_blocks = 16'(n);
        cycle();
        tx_start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0, k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            cycle();
            k++;
        end
        chk({tag, "_timeout"}, done_cnt != d0, 1);
    endtask

    task automatic compare_beats(input string tag);
        int n;
        chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic clr();
        n_reads = 0;
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        logic [127:0] b0, b1;
        int k, d0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fifo_tready", fifo_read_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        reset_n = 1'b1;
        cycle();

        // Single known block
        b0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        fifo_q.push_back(b0);
        add_exp(b0, 1);
        clr();
        start(1);
        run_until_done("single", 50);
        compare_beats("single");
        chk("single_reads", n_reads, 1);
        chk("single_done_lat", done_cyc, last_cyc + 1);
        chk("single_busy_cycles", busy_cnt, 5);
        repeat (3) cycle();
        chk("single_done_pulse", done_cnt, 1);

        // Three blocks at full rate
        fill(3);
        clr();
        start(3);
        run_until_done("three", 100);
        compare_beats("three");
        chk("three_reads", n_reads, 3);
        chk("three_busy_cycles", busy_cnt, 15);

        // Backpressure pattern within one block
        fill(1);
        pat_q = '{1, 0, 0, 1, 0, 1, 1};
        start(1);
        run_until_done("bp", 50);
        compare_beats("bp");
        chk("bp_pattern_used", pat_q.size(), 0);

        // FIFO empty for 20 cycles
        clr();
        start(1);
        watch_empty = 1;
        repeat (20) cycle();
        watch_empty = 0;
        chk("empty_wait", bad_empty, 0);
        fill(1);
        run_until_done("empty", 50);
        compare_beats("empty");
        chk("empty_reads", n_reads, 1);

        // Zero-length start ignored
        clr();
        start(0);
        repeat (10) cycle();
        chk("zero_busy", busy_cnt, 0);
        chk("zero_done", done_cnt, 0);

        // Start while busy must not change the length
        fill(2);
        clr();
        start(2);
        tx_start = 1'b1;
        tx_blocks = 16'd5;
        repeat (6) cycle();
        tx_start = 1'b0;
        run_until_done("busy_start", 100);
        compare_beats("busy_start");
        chk("busy_start_reads", n_reads, 2);
        repeat (5) cycle();
        chk("busy_start_done", done_cnt, 1);

        // Start held high: a second packet is accepted in the done cycle
        for (int i = 0; i < 2; i++) begin
            b0 = rnd128();
            fifo_q.push_back(b0);
            add_exp(b0, 1);
        end
        clr();
        tx_start = 1'b1;
        tx_blocks = 16'd1;
        run_until_done("coinc_a", 50);
        tx_start = 1'b0;
        run_until_done("coinc_b", 50);
        compare_beats("coinc");
        chk("coinc_reads", n_reads, 2);

        // Reset after the second beat
        b0 = rnd128();
        b1 = rnd128();
        fifo_q.push_back(b0);
        fifo_q.push_back(b1);
        start(1);
        k = 0;
        while (obs_q.size() < 2 && k < 50) begin
            cycle();
            k++;
        end
        chk("rst_mid_reach", obs_q.size(), 2);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_tdata", m_axis_tdata, 0);
        chk("rst_mid_tlast", m_axis_tlast, 0);
        chk("rst_mid_fifo_tready", fifo_read_tready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        prev_stall = 0;
        obs_q.delete();
        exp_q.delete();
        add_exp(b1, 1);
        start(1);
        run_until_done("rst_after", 50);
        compare_beats("rst_after");

        // Randomized packets with random ready and FIFO valid
        rand_ready = 1;
        rand_fifo = 1;
        for (int p = 0; p < 6; p++) begin
            d0 = $urandom_range(1, 4);
            fill(d0);
            clr();
            start(d0);
            run_until_done($sformatf("rand%0d", p), 600);
            compare_beats($sformatf("rand%0d", p));
            chk($sformatf("rand%0d_reads", p), n_reads, d0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_block_tx.md
Name: axis_block_tx

Overview:
- Read-side consumer for the 128-bit block FIFO.
- Pulls whole blocks through the FIFO read port's TVALID/TREADY handshake and serializes each block into 32-bit AXI-Stream master beats.
- Asserts TLAST on the final beat of a packet of tx_blocks blocks.
- Sits between the output FIFO and the DMA-facing M_AXIS port.

Parameters:
- DATA_WIDTH, 128, FIFO block width; must equal WORDS*AXIS_WIDTH.
- AXIS_WIDTH, 32, M_AXIS TDATA width.
- WORDS, 4, beats per block.
- CNT_WIDTH, 16, width of the packet block counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- tx_start  in  1  one-cycle request to send a packet.
- tx_blocks  in  CNT_WIDTH  packet length in blocks; sampled when tx_start is accepted.
- busy  out  1  high from accepted start until the last beat handshakes.
- done  out  1  one-cycle pulse after the last beat handshakes.
- fifo_rdata  in  DATA_WIDTH  FIFO read data.
- fifo_read_tvalid  in  1  FIFO read valid.
- fifo_read_tready  out  1  FIFO read ready.
- m_axis_tdata  out  AXIS_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of packet.

Behaviour:
- Reset: async on reset_n low. All state and outputs go to 0: busy, done, fifo_read_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, counters; state=IDLE. Reset mid-packet abandons the packet; FIFO contents are not touched.
- State machine: IDLE, FETCH, SEND; all outputs registered or decoded from registered state.
- IDLE:
  - tx_start=1 with tx_blocks!=0: latch blocks_left=tx_blocks, busy<=1, go to FETCH.
  - tx_start with tx_blocks==0: ignored; no busy, no done.
  - tx_start while busy is ignored.
- FETCH:
  - fifo_read_tready=1, decoded from state only; no combinational path from fifo_read_tvalid.
  - On fifo_read_tvalid && fifo_read_tready: capture fifo_rdata into block register, word_idx<=0, go to SEND.
  - Next cycle: m_axis_tvalid=1, tdata=bits[127:96].
  - Waits indefinitely while FIFO is empty or its tvalid is low; tvalid dropping without a handshake is legal.
- SEND:
  - Beat order is MSW first: [127:96], [95:64], [63:32], [31:0].
  - tdata, tvalid and tlast stay stable until m_axis_tready=1; no beat is dropped or duplicated under backpressure.
  - On handshake with word_idx<WORDS-1: word_idx+1, next word presented the following cycle (back-to-back beats).
  - On handshake of word WORDS-1: blocks_left-1.
    - If blocks_left was 1: tvalid<=0, tlast<=0, busy<=0, done<=1 for one cycle, go to IDLE.
    - Otherwise go to FETCH; tvalid is low during FETCH.
  - m_axis_tlast=1 only on word WORDS-1 when blocks_left==1.
- Throughput: minimum WORDS+1 cycles per block (1 FETCH + 4 SEND) with FIFO data ready and tready held high.
- Counter: blocks_left is CNT_WIDTH bits, no wrap (it only decrements from a nonzero value). Max packet 65535 blocks.
- done and a new tx_start may coincide: start is accepted, since the state is IDLE in that cycle.

Optional Feature:
- AXIS_TX_BSWAP_EN:
  - Defined: each 32-bit beat is byte-reversed (tdata[7:0] = word[31:24], etc.); word order is unchanged.
  - Undefined: beats pass through unmodified.
  - No effect on timing or handshakes.

Test Plan:
- Single block: FIFO holds 0x00112233_44556677_8899AABB_CCDDEEFF; tx_blocks=1, tready=1.
  - Beats 00112233, 44556677, 8899AABB, CCDDEEFF; tlast only on the 4th.
  - done pulses the cycle after the 4th handshake; exactly 1 FIFO read.
- Three-block packet, tready=1: 12 beats; tlast only on beat 12; 3 FIFO handshakes; busy high throughout; total 15 cycles from first FETCH.
- Backpressure: tready pattern 1,0,0,1,0,1,1 during a block. tdata/tvalid stay constant across stalls; order is preserved.
- Empty FIFO: start with FIFO empty for 20 cycles. fifo_read_tready stays high, tvalid stays 0; after data is written, the normal 4 beats follow.
- Starts ignored:
  - tx_blocks=0: busy stays 0, done stays 0.
  - tx_start while busy: no effect on the current packet's length.
- Reset mid-packet: reset_n low after beat 2 of 4. All outputs 0 immediately; a new tx_blocks=1 start afterwards sends the next FIFO block cleanly with tlast.
